// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared types and helpers for the dual-port-RAM FIFO controller.
// The output-register action is named here so the top reads as a decode of it.
package dpram_fifo_ctrl_pkg;

    // What the one-entry output register does on the coming edge.
    typedef enum logic [1:0] {
        OutHold,
        OutLoad,
        OutDrain
    } out_op_e;

    // Refill the output register whenever the RAM holds data and the register
    // is either empty or being popped this cycle.
    function automatic logic out_load(input logic ram_has_data, input logic out_valid,
                                      input logic deq);
        return ram_has_data & (~out_valid | deq);
    endfunction

    function automatic out_op_e out_next_op(input logic ram_has_data, input logic out_valid,
                                            input logic deq);
        if (out_load(ram_has_data, out_valid, deq)) begin
            return OutLoad;
        end else if (deq && out_valid) begin
            return OutDrain;
        end
        return OutHold;
    endfunction

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// FIFO handshake and RAM-port bundle for dpram_fifo_ctrl.
// master = FIFO user, slave = controller, ram = the DualPortRam side.
interface dpram_fifo_ctrl_if #(
    parameter int unsigned addrWidth = 5,
    parameter int unsigned dataWidth = 16
) ();

    logic                 ENQ;
    logic [dataWidth-1:0] D_IN;
    logic                 FULL_N;
    logic                 DEQ;
    logic [dataWidth-1:0] D_OUT;
    logic                 EMPTY_N;
    logic [addrWidth:0]   COUNT;

    logic                 RAM_WE;
    logic [addrWidth-1:0] RAM_WADDR;
    logic [dataWidth-1:0] RAM_DIN;
    logic [addrWidth-1:0] RAM_RADDR;
    logic [dataWidth-1:0] RAM_DOUT;

    modport master (
        output ENQ, D_IN, DEQ,
        input  FULL_N, D_OUT, EMPTY_N, COUNT
    );

    modport slave (
        input  ENQ, D_IN, DEQ, RAM_DOUT,
        output FULL_N, D_OUT, EMPTY_N, COUNT, RAM_WE, RAM_WADDR, RAM_DIN, RAM_RADDR
    );

    modport ram (
        input  RAM_WE, RAM_WADDR, RAM_DIN, RAM_RADDR,
        output RAM_DOUT
    );

endinterface

// File: rtl/dpram_fifo_ctrl.sv
// Single-clock FIFO controller around a sync-write / comb-read dual-port RAM,
// with a registered first-word-fall-through output stage (capacity DEPTH+1).
module dpram_fifo_ctrl
    import dpram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned addrWidth     = 5,
    parameter int unsigned dataWidth     = 16,
    parameter bit          AssertIllegal = 1'b1
) (
    input logic              CLK,
    input logic              RST,
    input logic              CLR,
    dpram_fifo_ctrl_if.slave bus
);

    localparam int unsigned Depth    = 1 << addrWidth;
    localparam int unsigned PtrWidth = addrWidth + 1;

    typedef logic [PtrWidth-1:0] ptr_t;

    ptr_t                 wr_ptr_q, wr_ptr_d;
    ptr_t                 rd_ptr_q, rd_ptr_d;
    ptr_t                 ram_cnt;
    logic                 out_valid_q, out_valid_d;
    logic [dataWidth-1:0] out_data_q, out_data_d;
    logic                 full_n;
    logic                 enq_ok;
    out_op_e              out_op;

    // Extra MSB on the pointers separates full from empty at equal index bits.
    assign ram_cnt = wr_ptr_q - rd_ptr_q;
    assign full_n  = (ram_cnt != ptr_t'(Depth));
    assign enq_ok  = bus.ENQ & full_n & ~RST & ~CLR;

    // Load decision uses start-of-cycle pointers, so a same-cycle write is
    // never read back through the RAM's old-data read port.
    assign out_op = out_next_op(ram_cnt != '0, out_valid_q, bus.DEQ);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (enq_ok) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end

        unique case (out_op)
            OutLoad: begin
                out_data_d  = bus.RAM_DOUT;
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + ptr_t'(1);
            end
            OutDrain: begin
                out_valid_d = 1'b0;
            end
            OutHold: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.FULL_N    = full_n;
    assign bus.EMPTY_N   = out_valid_q;
    assign bus.COUNT     = ram_cnt + ptr_t'(out_valid_q);
    assign bus.D_OUT     = out_data_q;

    assign bus.RAM_WE    = enq_ok;
    assign bus.RAM_WADDR = wr_ptr_q[addrWidth-1:0];
    assign bus.RAM_DIN   = bus.D_IN;
    assign bus.RAM_RADDR = rd_ptr_q[addrWidth-1:0];

    // Protocol misuse is harmless to state but flags a broken producer/consumer.
    enq_when_full: assert property (
        @(posedge CLK) disable iff (RST || CLR || !AssertIllegal)
        !(bus.ENQ && !full_n)
    );

    deq_when_empty: assert property (
        @(posedge CLK) disable iff (RST || CLR || !AssertIllegal)
        !(bus.DEQ && !out_valid_q)
    );

endmodule
